// File: rtl/decoder_2_4_reg.sv
// decoder_2_4_reg: registered 2-to-4 one-hot decoder with invalid-sample counting and consecutive-invalid fault latch
module decoder_2_4_reg #(
    parameter bit HOLD_ON_INVALID = 1'b0,
    parameter int FAULT_LIMIT     = 3,
    parameter int ERR_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       d_in,
    input  logic             invalid_in,
    input  logic             fault_clr,
    output logic [3:0]       d_out,
    output logic             out_valid,
    output logic             invalid_out,
    output logic             fault,
    output logic [ERR_W-1:0] err_count
);
    localparam int CW = (FAULT_LIMIT > 0) ? $clog2(FAULT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(FAULT_LIMIT);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_consec;
    logic [3:0]    r_last_good;
    logic [CW-1:0] w_consec_nx;
    logic [3:0]    w_onehot;
    logic          w_trip;
    assign w_onehot    = 4'b0001 << d_in;
    assign w_consec_nx = (r_consec == LIM) ? r_consec : r_consec + 1'b1;
    assign w_trip      = (FAULT_LIMIT > 0) && (w_consec_nx == LIM);
    assign fault       = (r_state == S_FAULT);
    always_ff @(posedge clk) begin
        if (rst || fault_clr) begin
            r_state     <= S_IDLE;
            r_consec    <= '0;
            r_last_good <= '0;
            d_out       <= '0;
            out_valid   <= 1'b0;
            invalid_out <= 1'b0;
            err_count   <= '0;
        end else if (r_state == S_FAULT) begin
            d_out       <= '0;
            out_valid   <= 1'b0;
            invalid_out <= 1'b0;
        end else if (in_valid) begin
            out_valid   <= 1'b1;
            invalid_out <= invalid_in;
            if (invalid_in) begin
                d_out     <= HOLD_ON_INVALID ? r_last_good : 4'b0000;
                err_count <= &err_count ? err_count : err_count + 1'b1;
                r_consec  <= w_consec_nx;
                r_state   <= w_trip ? S_FAULT : S_RUN;
            end else begin
                d_out       <= w_onehot;
                r_last_good <= w_onehot;
                r_consec    <= '0;
                r_state     <= S_RUN;
            end
        end else begin
            out_valid   <= 1'b0;
            invalid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decoder_2_4_reg.sv
// tb_decoder_2_4_reg: scoreboard bench driving three parameterisations of decoder_2_4_reg with shared stimulus
module tb_decoder_2_4_reg;
    typedef struct packed {
        logic [3:0] d;
        logic       inv;
        logic       flt;
        logic [7:0] err;
    } txn_t;

    localparam bit HOLD [3] = '{1'b0, 1'b1, 1'b0};
    localparam int LIM  [3] = '{3, 3, 0};
    localparam int EMAX [3] = '{255, 255, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] d_in = 2'd0;
    logic       invalid_in = 1'b0;
    logic       fault_clr = 1'b0;

    logic [3:0] d_out [3];
    logic       ov    [3];
    logic       io    [3];
    logic       flt   [3];
    logic [7:0] err   [3];
    logic [1:0] err_c;

    bit         m_fault [3];
    int         m_consec[3];
    int         m_err   [3];
    logic [3:0] m_lg    [3];
    logic [3:0] m_dout  [3];

    txn_t q0[$];
    txn_t q1[$];
    txn_t q2[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoder_2_4_reg #(.HOLD_ON_INVALID(1'b0), .FAULT_LIMIT(3), .ERR_W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in), .invalid_in(invalid_in),
        .fault_clr(fault_clr), .d_out(d_out[0]), .out_valid(ov[0]), .invalid_out(io[0]),
        .fault(flt[0]), .err_count(err[0]));
    decoder_2_4_reg #(.HOLD_ON_INVALID(1'b1), .FAULT_LIMIT(3), .ERR_W(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in), .invalid_in(invalid_in),
        .fault_clr(fault_clr), .d_out(d_out[1]), .out_valid(ov[1]), .invalid_out(io[1]),
        .fault(flt[1]), .err_count(err[1]));
    decoder_2_4_reg #(.HOLD_ON_INVALID(1'b0), .FAULT_LIMIT(0), .ERR_W(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in), .invalid_in(invalid_in),
        .fault_clr(fault_clr), .d_out(d_out[2]), .out_valid(ov[2]), .invalid_out(io[2]),
        .fault(flt[2]), .err_count(err_c));
    assign err[2] = {6'd0, err_c};

    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    endfunction

    function automatic txn_t qpop(input int k);
        txn_t t;
        if (k == 0) t = q0.pop_front();
        else if (k == 1) t = q1.pop_front();
        else t = q2.pop_front();
        return t;
    endfunction

    task automatic qpush(input int k, input txn_t t);
        if (k == 0) q0.push_back(t);
        else if (k == 1) q1.push_back(t);
        else q2.push_back(t);
    endtask

    // reference: what each sampled edge should do, expressed as counters and flags
    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            if (rst || fault_clr) begin
                m_fault[k] = 1'b0; m_consec[k] = 0; m_err[k] = 0; m_lg[k] = 4'd0; m_dout[k] = 4'd0;
            end else if (m_fault[k]) begin
                m_dout[k] = 4'd0;
            end else if (in_valid) begin
                if (!invalid_in) begin
                    m_dout[k]   = 4'(1 << d_in);
                    m_lg[k]     = m_dout[k];
                    m_consec[k] = 0;
                end else begin
                    m_dout[k] = HOLD[k] ? m_lg[k] : 4'd0;
                    if (m_err[k] < EMAX[k]) m_err[k]++;
                    m_consec[k]++;
                    if (LIM[k] > 0 && m_consec[k] >= LIM[k]) m_fault[k] = 1'b1;
                end
                qpush(k, '{d: m_dout[k], inv: invalid_in, flt: m_fault[k], err: 8'(m_err[k])});
            end
        end
    endtask

    task automatic step(input logic v, input logic [1:0] d, input logic inv, input logic clr, input logic r);
        in_valid = v; d_in = d; invalid_in = inv; fault_clr = clr; rst = r;
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        txn_t t;
        int   n;
        for (int k = 0; k < 3; k++) begin
            n = qsize(k);
            if (ov[k]) begin
                chk("spurious_valid", k, 8'(n == 0), 8'd0);
                if (n > 0) begin
                    t = qpop(k);
                    chk("d_out", k, 8'(d_out[k]), 8'(t.d));
                    chk("invalid_out", k, 8'(io[k]), 8'(t.inv));
                    chk("fault", k, 8'(flt[k]), 8'(t.flt));
                    chk("err_count", k, err[k], t.err);
                end
            end else begin
                chk("missing_valid", k, 8'(n), 8'd0);
                if (n > 0) t = qpop(k);
                chk("idle_invalid_out", k, 8'(io[k]), 8'd0);
                chk("idle_d_out", k, 8'(d_out[k]), 8'(m_dout[k]));
                chk("idle_fault", k, 8'(flt[k]), 8'(m_fault[k]));
                chk("idle_err_count", k, err[k], 8'(m_err[k]));
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int d = 0; d < 4; d++) step(1, 2'(d), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0);
        step(1, 3, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 2, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 3, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 3, 0, 1, 0);
        step(1, 3, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 2'($urandom_range(0, 3)), 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 2, 0, 1, 1);
        step(1, 0, 1, 0, 0);
        step(1, 3, 1, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 3,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("drain", k, 8'(qsize(k)), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decoder_2_4_reg.md
Name: decoder_2_4_reg

Overview:
- Registered 2-to-4 decoder. It is the receive-side counterpart of the team's 4-to-2 encoder.
- It takes the encoder's 2-bit code plus its invalid flag, sample by sample, and regenerates a one-hot 4-bit word one cycle later.
- It counts invalid samples and latches a fault after a run of consecutive invalid samples, until software clears it.
- It sits directly downstream of the encoder in the encode/decode loopback path.

Parameters:
- HOLD_ON_INVALID, 0: on an invalid sample, 0 drives d_out=4'b0000; 1 holds the last good one-hot value.
- FAULT_LIMIT, 3: number of consecutive invalid samples that trips fault. 0 disables fault detection.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  sample strobe for d_in/invalid_in.
- d_in  input  2  encoded index from the encoder.
- invalid_in  input  1  encoder invalid flag (no or illegal input bit set).
- fault_clr  input  1  single-cycle clear of fault state and counters.
- d_out  output  4  registered one-hot decode.
- out_valid  output  1  d_out/invalid_out valid this cycle.
- invalid_out  output  1  the sample presented this cycle was invalid.
- fault  output  1  consecutive-invalid fault latched.
- err_count  output  ERR_W  total invalid samples since reset/clear; saturating.

Behaviour:
- Synchronous reset (rst=1 at a clock edge):
  - d_out=0, out_valid=0, invalid_out=0, fault=0, err_count=0.
  - Internal consecutive-invalid counter (consec) = 0, last-good register = 0, state=IDLE.
  - rst overrides every other input, including mid-FAULT and mid-stream.
- Latency: exactly 1 cycle from an accepted sample to out_valid=1. No backpressure; every accepted sample produces one output cycle.
- A sample is accepted when in_valid=1, state!=FAULT and fault_clr=0.
- Accepted valid sample (invalid_in=0):
  - d_out <= 4'b0001 << d_in; last-good <= same value.
  - out_valid<=1, invalid_out<=0, consec<=0.
  - State moves to RUN.
- Accepted invalid sample (invalid_in=1):
  - out_valid<=1, invalid_out<=1.
  - d_out <= last-good if HOLD_ON_INVALID=1, else 0. In IDLE, last-good is 0.
  - d_in is ignored.
  - err_count increments, saturating at 2^ERR_W-1.
  - consec increments, saturating at FAULT_LIMIT.
- No sample (in_valid=0): out_valid<=0, invalid_out<=0, d_out holds its value, counters hold.
- FSM states: IDLE, RUN, FAULT.
  - IDLE -> RUN on the first accepted sample, valid or invalid.
  - RUN -> FAULT when an accepted invalid sample makes consec==FAULT_LIMIT (FAULT_LIMIT>0). That sample's output is still presented normally (out_valid=1, invalid_out=1), and fault=1 in the same cycle.
  - FAULT:
    - fault=1, out_valid=0 and invalid_out=0 from the next cycle on; d_out=0.
    - Inputs are ignored; err_count and consec are frozen.
  - Any state with fault_clr=1 -> IDLE next cycle: fault=0, consec=0, err_count=0, last-good=0, d_out=0, out_valid=0.
- Simultaneous fault_clr and in_valid: fault_clr wins and the sample is dropped (out_valid=0 next cycle).
- Simultaneous rst and fault_clr: rst semantics apply; the results are identical.
- err_count saturation: remains at all-ones and does not wrap; fault logic is unaffected.
- FAULT_LIMIT=0: the fault output is tied low and the FAULT state is unreachable.
- X on d_in while invalid_in=1 must not propagate to d_out.

Test Plan:
- Reset then in_valid=1 with d_in=0,1,2,3 on consecutive cycles -> d_out=0001,0010,0100,1000 each one cycle later; out_valid=1, invalid_out=0, err_count=0.
- HOLD_ON_INVALID=0: valid d_in=2, then one invalid sample -> d_out=0100 then 0000, invalid_out=1, err_count=1. With HOLD_ON_INVALID=1 the same stimulus gives d_out=0100, 0100.
- FAULT_LIMIT=3: invalid, invalid, valid(1), invalid, invalid, invalid -> consec resets after the valid sample; fault=1 on the 3rd output of the final run, err_count=5; further in_valid samples produce out_valid=0.
- In FAULT, pulse fault_clr together with in_valid=1 -> sample dropped, out_valid=0; next cycle fault=0, err_count=0; the following valid d_in=3 yields d_out=1000.
- ERR_W=2, FAULT_LIMIT=0: six invalid samples -> err_count sequence 1,2,3,3,3,3 and fault stays 0.
- Assert rst for one cycle mid-stream, with out_valid=1 and err_count=2 -> all outputs 0 next cycle; the next sample is handled as from IDLE (HOLD_ON_INVALID=1 invalid gives d_out=0000).
